// File: rtl/uart_tx_fifo_pkg.sv
// Shared types and constants for the buffered UART transmitter: FSM states,
// status bit positions and register offsets.
package uart_tx_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int unsigned ST_FULL      = 0;
  localparam int unsigned ST_EMPTY     = 1;
  localparam int unsigned ST_BUSY      = 2;
  localparam int unsigned ST_OVF       = 3;
  localparam int unsigned ST_COUNT_LSB = 8;
  localparam int unsigned ST_COUNT_W   = 8;

  localparam logic [31:0] OFS_DATA = 32'd0;
  localparam logic [31:0] OFS_STAT = 32'd4;

  // Assemble the status register word from its fields.
  function automatic logic [31:0] pack_status(input logic [ST_COUNT_W-1:0] count,
                                              input logic ovf,
                                              input logic busy,
                                              input logic empty,
                                              input logic full);
    logic [31:0] s;
    s                                = '0;
    s[ST_FULL]                       = full;
    s[ST_EMPTY]                      = empty;
    s[ST_BUSY]                       = busy;
    s[ST_OVF]                        = ovf;
    s[ST_COUNT_LSB +: ST_COUNT_W]    = count;
    return s;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// CPU data-memory bus slice seen by the UART: address, strobes, store data
// and the combinational load readback.
interface uart_tx_fifo_if;
  logic [31:0] addr;
  logic        is_store;
  logic        is_load;
  logic [31:0] w_data;
  logic [31:0] r_data;
  logic        hit;

  modport master (output addr, output is_store, output is_load, output w_data,
                  input  r_data, input hit);
  modport slave  (input  addr, input  is_store, input  is_load, input  w_data,
                  output r_data, output hit);
endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Synchronous FIFO; a push while full is still accepted when a pop happens on
// the same edge. Contents are not reset, only pointers and level.
module uart_tx_fifo_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [WIDTH-1:0]             din_i,
  output logic [WIDTH-1:0]             dout_c_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, empty_q;
  logic             push_ok;

  assign push_ok = push_i && (!full_q || pop_i);

  always_comb begin
    wptr_d  = push_ok ? wptr_q + PTR_W'(1) : wptr_q;
    rptr_d  = pop_i   ? rptr_q + PTR_W'(1) : rptr_q;
    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= (count_d == CNT_FULL);
      empty_q <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wptr_q] <= din_i;
    end
  end

  assign dout_c_o = mem_q[rptr_q];
  assign count_o  = count_q;
  assign full_o   = full_q;
  assign empty_o  = empty_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter on the CPU data bus: stores enqueue bytes, a
// status word reports level/busy/overflow, frames go out back-to-back.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned STOP_BITS = 1,
  parameter logic [31:0] BASE_ADDR = 32'hf6ff_f070
) (
  input  logic          sysclk,
  input  logic          cpu_resetn,
  uart_tx_fifo_if.slave bus,
  output logic          uart_tx
);

  localparam int unsigned DIV    = CLK_HZ / BAUD;
  localparam int unsigned BAUD_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BIT_W  = $clog2(DATA_BITS);
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

  localparam logic [31:0]       DATA_ADDR = BASE_ADDR + OFS_DATA;
  localparam logic [31:0]       STAT_ADDR = BASE_ADDR + OFS_STAT;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIV - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_fifo: CLK_HZ/BAUD must be at least 2");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: DEPTH must be a power of two >= 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data
    $error("uart_tx_fifo: DATA_BITS must be in 5..8");
  end

  tx_state_e              state_q, state_d;
  logic [BAUD_W-1:0]      baud_q, baud_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   tx_q, tx_d;
  logic                   ovf_q, ovf_d;
  logic                   baud_tick;
  logic                   pop;

  logic                   data_sel, stat_sel;
  logic                   data_wr, stat_clr, ovf_set;
  logic [DATA_BITS-1:0]   fifo_dout;
  logic [CNT_W-1:0]       fifo_count;
  logic                   fifo_full, fifo_empty;
  logic                   unused_wdata;

  assign data_sel     = (bus.addr == DATA_ADDR);
  assign stat_sel     = (bus.addr == STAT_ADDR);
  assign data_wr      = bus.is_store && data_sel;
  assign stat_clr     = bus.is_store && stat_sel && bus.w_data[ST_OVF];
  assign unused_wdata = ^bus.w_data;

  uart_tx_fifo_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (sysclk),
    .rst_n    (cpu_resetn),
    .push_i   (data_wr),
    .pop_i    (pop),
    .din_i    (bus.w_data[DATA_BITS-1:0]),
    .dout_c_o (fifo_dout),
    .count_o  (fifo_count),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  // A dropped byte sets the sticky flag; setting beats a same-cycle clear.
  assign ovf_set = data_wr && fifo_full && !pop;
  assign ovf_d   = ovf_set || (ovf_q && !stat_clr);

  assign baud_tick = (baud_q == BAUD_LAST);

  // Next-state logic; tx_d is the line level for the state being entered.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    baud_d  = (state_q == IDLE || baud_tick) ? '0 : baud_q + BAUD_W'(1);
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          tx_d    = 1'b0;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_tick) begin
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      STOP: begin
        if (baud_tick) begin
          if (bit_q != STOP_LAST) begin
            bit_d = bit_q + BIT_W'(1);
          end else if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_dout;
            tx_d    = 1'b0;
            bit_d   = '0;
            state_d = START;
          end else begin
            bit_d   = '0;
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
    end
  end

  assign uart_tx = tx_q;

  // Load readback: status word at the status address, zero elsewhere.
  always_comb begin
    bus.hit    = bus.is_load && (data_sel || stat_sel);
    bus.r_data = '0;
    if (bus.is_load && stat_sel) begin
      bus.r_data = pack_status(ST_COUNT_W'(fifo_count), ovf_q, (state_q != IDLE),
                               fifo_empty, fifo_full);
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a queue/frame-time model checked every cycle, plus
// directed scenarios with hand-computed line levels and status words.
module tb_uart_tx_fifo;

  localparam int unsigned DIV       = 10;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned NBITS     = 8;
  localparam int unsigned NSTOP     = 1;
  localparam int unsigned FRAME_LEN = (1 + NBITS + NSTOP) * DIV;
  localparam logic [31:0] BASE      = 32'hf6ff_f070;
  localparam logic [31:0] DATA_A    = BASE;
  localparam logic [31:0] STAT_A    = BASE + 32'd4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic uart_tx;

  uart_tx_fifo_if bus ();

  uart_tx_fifo #(
    .CLK_HZ    (100),
    .BAUD      (10),
    .DEPTH     (DEPTH),
    .DATA_BITS (NBITS),
    .STOP_BITS (NSTOP),
    .BASE_ADDR (BASE)
  ) dut (
    .sysclk     (clk),
    .cpu_resetn (rst_n),
    .bus        (bus.slave),
    .uart_tx    (uart_tx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: FIFO as a queue, the transmitter as "which frame, how many cycles in".
  logic [7:0]             mq[$];
  logic                   m_ovf, m_busy, m_tx, m_set;
  int                     m_t;
  logic [NBITS+NSTOP:0]   m_frame;
  logic [7:0]             m_byte;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_ovf   = 1'b0;
      m_busy  = 1'b0;
      m_t     = 0;
      m_frame = '1;
      m_tx    = 1'b1;
    end else begin
      if (m_busy && m_t < FRAME_LEN - 1) begin
        m_t++;
      end else if (mq.size() != 0) begin
        m_byte  = mq.pop_front();
        m_frame = {{NSTOP{1'b1}}, m_byte, 1'b0};
        m_t     = 0;
        m_busy  = 1'b1;
      end else begin
        m_busy = 1'b0;
      end
      m_set = 1'b0;
      if (bus.is_store && bus.addr == DATA_A) begin
        if (mq.size() < DEPTH) mq.push_back(bus.w_data[7:0]);
        else m_set = 1'b1;
      end
      if (bus.is_store && bus.addr == STAT_A && bus.w_data[3]) m_ovf = 1'b0;
      if (m_set) m_ovf = 1'b1;
      m_tx = m_busy ? m_frame[m_t / DIV] : 1'b1;
    end
  end

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s       = '0;
    s[0]    = (mq.size() == DEPTH);
    s[1]    = (mq.size() == 0);
    s[2]    = m_busy;
    s[3]    = m_ovf;
    s[15:8] = 8'(mq.size());
    return s;
  endfunction

  logic c_hit;
  logic [31:0] c_rdata;
  always @(negedge clk) begin
    c_hit   = bus.is_load && (bus.addr == DATA_A || bus.addr == STAT_A);
    c_rdata = (bus.is_load && bus.addr == STAT_A) ? model_status() : 32'h0;
    check("cyc_line",   32'(uart_tx), 32'(m_tx));
    check("cyc_hit",    32'(bus.hit), 32'(c_hit));
    check("cyc_r_data", bus.r_data,   c_rdata);
  end

  // Idle bus keeps a status load going so the per-cycle check sees status.
  task automatic bus_idle();
    bus.is_store = 1'b0;
    bus.is_load  = 1'b1;
    bus.addr     = STAT_A;
    bus.w_data   = '0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    bus.is_load  = 1'b0;
    bus.is_store = 1'b1;
    bus.addr     = a;
    bus.w_data   = d;
    @(posedge clk);
    #1;
    bus_idle();
  endtask

  task automatic stat_is(input string name, input logic [31:0] exp);
    #1;
    check(name, bus.r_data, exp);
  endtask

  int a5_bits[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

  initial begin
    bus_idle();
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_line", 32'(uart_tx), 32'h1);
    stat_is("reset_status", 32'h2);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single 0xA5 frame, sampled mid-bit.
    store(DATA_A, 32'hA5);
    @(posedge clk);
    for (int k = 0; k < 10; k++) begin
      repeat (5) @(posedge clk);
      #1;
      check($sformatf("a5_bit%0d", k), 32'(uart_tx), 32'(a5_bits[k]));
      stat_is($sformatf("a5_busy%0d", k), 32'h6);
      repeat (5) @(posedge clk);
    end
    stat_is("a5_done", 32'h2);

    // Back-to-back frames.
    store(DATA_A, 32'h01);
    store(DATA_A, 32'h02);
    store(DATA_A, 32'h03);
    stat_is("b2b_count2", 32'h204);
    repeat (99) @(posedge clk);
    stat_is("b2b_second_pop", 32'h104);
    check("b2b_start2", 32'(uart_tx), 32'h0);
    repeat (100) @(posedge clk);
    stat_is("b2b_third_pop", 32'h006);
    check("b2b_start3", 32'(uart_tx), 32'h0);
    repeat (100) @(posedge clk);
    stat_is("b2b_idle", 32'h2);
    check("b2b_idle_line", 32'(uart_tx), 32'h1);

    // Overflow: six stores, one dropped.
    for (int i = 0; i < 6; i++) store(DATA_A, 32'(8'h10 + i));
    stat_is("ovf_full", 32'h40D);
    store(STAT_A, 32'h8);
    stat_is("ovf_cleared", 32'h405);

    // Store on the STOP->START pop edge while full.
    repeat (94) @(posedge clk);
    #1;
    store(DATA_A, 32'h5A);
    stat_is("push_on_pop", 32'h405);
    check("push_on_pop_line", 32'(uart_tx), 32'h0);

    // Asynchronous reset during data bit 1 (a zero) of 0x11.
    repeat (25) @(posedge clk);
    #2;
    check("pre_reset_line", 32'(uart_tx), 32'h0);
    rst_n = 1'b0;
    #1;
    check("async_reset_line", 32'(uart_tx), 32'h1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    stat_is("post_reset_status", 32'h2);
    repeat (150) @(posedge clk);
    #1;
    check("post_reset_quiet", 32'(uart_tx), 32'h1);
    stat_is("post_reset_idle", 32'h2);

    // Address decode.
    bus.addr = BASE + 32'd8;
    #1;
    check("dec_off8_hit", 32'(bus.hit), 32'h0);
    check("dec_off8_rdata", bus.r_data, 32'h0);
    bus.addr = DATA_A;
    #1;
    check("dec_data_hit", 32'(bus.hit), 32'h1);
    check("dec_data_rdata", bus.r_data, 32'h0);
    bus.addr    = STAT_A;
    bus.is_load = 1'b0;
    #1;
    check("dec_noload_hit", 32'(bus.hit), 32'h0);
    check("dec_noload_rdata", bus.r_data, 32'h0);
    bus_idle();
    repeat (2) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered, parametrised UART transmitter with a memory-mapped data/status interface, the next-generation replacement for the store-triggered `uart` on the CPU data-memory bus. Stores to the data address enqueue bytes into a FIFO instead of requiring software to wait out each frame. A status register is readable by `LW` and reports FIFO level, busy state and a sticky overflow flag. It sits beside `data_mem` and `hardware_counter`, and its `r_data` is muxed into the load path by address decode.

## Interface
- `CLK_HZ`, 100_000_000, system clock frequency
- `BAUD`, 115200, line rate; `DIV = CLK_HZ/BAUD` (integer, ≥2)
- `DEPTH`, 16, FIFO entries; power of two, ≥2
- `DATA_BITS`, 8, bits per frame, 5..8
- `STOP_BITS`, 1, 1 or 2
- `BASE_ADDR`, 32'hf6fff070, data register address; status register at `BASE_ADDR+4`
- `sysclk`  in  1  single system clock, all state on rising edge
- `cpu_resetn`  in  1  asynchronous active-low reset
- `addr`  in  32  bus address (ALU result)
- `is_store`  in  1  store strobe for the current cycle
- `is_load`  in  1  load strobe for the current cycle
- `w_data`  in  32  store data; `[DATA_BITS-1:0]` used
- `r_data`  out  32  status readback, combinational
- `hit`  out  1  `is_load` and `addr` is `BASE_ADDR` or `BASE_ADDR+4`; steers the CPU load mux
- `uart_tx`  out  1  serial line, idle high

## Operation
- Data write: `is_store && addr==BASE_ADDR` pushes `w_data[DATA_BITS-1:0]`. The push is accepted if `count<DEPTH`, or if a pop occurs in the same cycle. Otherwise the byte is dropped and `ovf` is set.
- Status write: `is_store && addr==BASE_ADDR+4 && w_data[3]` clears `ovf`. If a clear and a new overflow happen in the same cycle, the set wins.
- Status read (`addr==BASE_ADDR+4`): `r_data = {16'b0, count[7:0], 4'b0, ovf, busy, empty, full}`.
- Data-address read returns 0 with `hit=1`. Any unmatched address gives `r_data=0`, `hit=0`.
- The transmitter state machine has four states:
  - `IDLE`: `uart_tx=1`. If the FIFO is non-empty, pop into the shift register and go to `START`.
  - `START`: `uart_tx=0` for DIV cycles, then go to `DATA`.
  - `DATA`: drive the shift register LSB first, DIV cycles per bit, DATA_BITS bits, then go to `STOP`.
  - `STOP`: `uart_tx=1` for STOP_BITS×DIV cycles. Then pop the next byte directly into `START` if the FIFO is non-empty (back-to-back, no idle cycle); otherwise go to `IDLE`.
- `busy` = state≠`IDLE`. `empty` = `count==0`. `full` = `count==DEPTH`.
- `count` width is `$clog2(DEPTH+1)`. Read/write pointers are `$clog2(DEPTH)` bits and wrap naturally.
- The baud counter is `$clog2(DIV)` bits; it counts 0..DIV-1 and reloads on every bit boundary.

## Timing
- Reset, asynchronous, mid-frame included: state=`IDLE`, pointers=0, `count`=0, `ovf`=0, baud counter=0, bit index=0, `uart_tx`=1 immediately. FIFO contents are discarded.
- `r_data` and `hit` are combinational from `addr`, `is_load` and registered status. Status reflects state before the current edge's push/pop.
- Push at edge N: `count` increments at edge N. From `IDLE`, the pop occurs at edge N+1 and the `uart_tx` falling edge is registered at N+1.
- Frame length is (1+DATA_BITS+STOP_BITS)×DIV cycles. The gap between consecutive queued frames is 0 cycles.
- `uart_tx` is driven from a flop (glitch-free).
- `busy` deasserts on the edge that returns the state machine to `IDLE`.

## Structure
- `uart_pkg`: state enum (`IDLE`, `START`, `DATA`, `STOP`), status bit positions (`ST_FULL=0`, `ST_EMPTY=1`, `ST_BUSY=2`, `ST_OVF=3`, `ST_COUNT_LSB=8`), register offsets (`OFS_DATA=0`, `OFS_STAT=4`).
- Sub-module `sync_fifo`: parameters `WIDTH` and `DEPTH`; ports push/pop/din/dout/count/full/empty. It implements the push-while-full-with-pop rule.
- Top: address decode, overflow flag, transmitter state machine, baud counter.
- Elaboration checks on `DIV≥2`, `DEPTH` power of two, and `STOP_BITS∈{1,2}`.

## Test plan
All scenarios use CLK_HZ=100, BAUD=10 (DIV=10), DEPTH=4, DATA_BITS=8, STOP_BITS=1.

- Single frame: store 0xA5 to BASE_ADDR → line 0,1,0,1,0,0,1,0,1,1, each held 10 cycles, starting one cycle after the store. `busy` reads 1 during the frame and returns to 0 after 100 cycles.
- Back-to-back: store 0x01, 0x02, 0x03 on consecutive cycles → three frames with no idle gap. Status `count` reads 2 right after the first pop and 0 after the third pop.
- Overflow: 6 stores on consecutive cycles starting from idle → 5 accepted (one popped early), 1 dropped. Status reads `ovf`=1 and `full`=1. A store of 0x8 to BASE_ADDR+4 clears `ovf`; `full` stays 1.
- Push-when-full-with-pop: hold FIFO full and store exactly on the STOP→START pop cycle → push accepted, `ovf` stays 0, `count` stays 4.
- Reset mid-frame: assert `cpu_resetn`=0 during the DATA bits → `uart_tx`=1 with no clock edge. After release, status=0x2 and no further frames are sent.
- Decode: load from BASE_ADDR+8 → `hit`=0, `r_data`=0. Load from BASE_ADDR → `hit`=1, `r_data`=0.
